// File: rtl/sec_lvl_switch_fsm.sv
// Sequences a security-level change: halt issue, drain the LSU, apply the new PMP level, flush, release.
// Optional timeout/abort path enabled by defining SEC_SWITCH_TIMEOUT_EN.
module sec_lvl_switch_fsm #(
  parameter int   MAX_OUTSTANDING = 4,
  parameter int   TIMEOUT_CYCLES  = 1024,
  parameter logic RESET_LVL       = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sec_lvl_req_i,
  input  logic core_idle_i,
  input  logic lsu_req_i,
  input  logic lsu_gnt_i,
  input  logic lsu_rvalid_i,
  output logic halt_o,
  output logic pmp_sec_lvl_o,
  output logic pmp_flush_o,
  output logic busy_o,
  output logic switch_done_o,
  output logic err_o
);

  localparam int CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    S_IDLE, S_HALT, S_DRAIN, S_APPLY, S_RELEASE, S_ABORT
  } state_t;

  state_t          r_state, w_state_next;
  logic            r_halt, r_busy, r_lvl, r_target;
  logic [CntW-1:0] r_outstanding, w_outstanding_next;
  logic            w_inc, w_dec, w_start, w_timeout;

  assign w_inc = lsu_req_i & lsu_gnt_i;
  assign w_dec = lsu_rvalid_i;

  always_comb begin
    w_outstanding_next = r_outstanding;
    if (w_inc && !w_dec && r_outstanding != CntMax) begin
      w_outstanding_next = r_outstanding + 1'b1;
    end else if (w_dec && !w_inc && r_outstanding != '0) begin
      w_outstanding_next = r_outstanding - 1'b1;
    end
  end

`ifdef SEC_SWITCH_TIMEOUT_EN
  localparam int TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] r_tmo_cnt;
  logic            r_blocked;

  assign w_timeout = ((r_state == S_HALT) || (r_state == S_DRAIN)) &&
                     (r_tmo_cnt == TmoW'(TIMEOUT_CYCLES - 1));
  assign w_start   = !r_blocked && (sec_lvl_req_i != r_lvl);
  assign err_o     = (r_state == S_ABORT);

  // After an abort, the requester must first agree with the applied level before a retry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tmo_cnt <= '0;
      r_blocked <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        r_tmo_cnt <= '0;
      end else if ((r_state == S_HALT) || (r_state == S_DRAIN)) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
      if (r_state == S_ABORT) begin
        r_blocked <= 1'b1;
      end else if (sec_lvl_req_i == r_lvl) begin
        r_blocked <= 1'b0;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_start   = (sec_lvl_req_i != r_lvl);
  assign err_o     = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_start) w_state_next = S_HALT;
      S_HALT: begin
        if (w_timeout)        w_state_next = S_ABORT;
        else if (core_idle_i) w_state_next = S_DRAIN;
      end
      // A response retiring the last transaction this cycle is enough; a new grant is not.
      S_DRAIN: begin
        if (w_timeout)                                     w_state_next = S_ABORT;
        else if (w_outstanding_next == '0 && !w_inc)       w_state_next = S_APPLY;
      end
      S_APPLY:   w_state_next = S_RELEASE;
      S_RELEASE: w_state_next = S_IDLE;
      S_ABORT:   w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= S_IDLE;
      r_halt        <= 1'b0;
      r_busy        <= 1'b0;
      r_lvl         <= RESET_LVL;
      r_target      <= RESET_LVL;
      r_outstanding <= '0;
    end else begin
      r_state       <= w_state_next;
      r_halt        <= (w_state_next == S_HALT) || (w_state_next == S_DRAIN) ||
                       (w_state_next == S_APPLY);
      r_busy        <= (w_state_next != S_IDLE);
      r_outstanding <= w_outstanding_next;
      if (r_state == S_IDLE && w_start) r_target <= sec_lvl_req_i;
      if (r_state == S_APPLY)           r_lvl    <= r_target;
    end
  end

  assign halt_o        = r_halt;
  assign busy_o        = r_busy;
  assign pmp_sec_lvl_o = r_lvl;
  assign pmp_flush_o   = (r_state == S_APPLY);
  assign switch_done_o = (r_state == S_RELEASE);

`ifndef SYNTHESIS
  a_cfg_sane: assert property (@(posedge clk_i) (MAX_OUTSTANDING > 0) && (TIMEOUT_CYCLES > 1));
  a_rvalid_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(lsu_rvalid_i && r_outstanding == '0));
`endif

endmodule
